// File: rtl/plab4_net_demux_q_pkg.sv
// Purpose: shared types and constants for the buffered plab4 domain demux.
// Latency: not applicable (types, constants and one helper only).
// Backpressure: not applicable.
package plab4_net_demux_q_pkg;

  // Occupancy state of one per-domain queue
  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_e;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_SAT = '1;

  // Increment that sticks at the saturation value instead of wrapping
  function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == DROP_CNT_SAT) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/plab4_net_demux_q_fifo.sv
// Purpose: single-domain FIFO holding control+data together; head is zeroed when empty.
// Latency: 1 cycle from enqueue edge to head visible on deq_val/deq_*.
// Backpressure: full blocks enqueue; deq_rdy low holds the head, never affects full combinationally.
module plab4_net_demux_q_fifo
  import plab4_net_demux_q_pkg::*;
#(
  parameter int p_msg_cnbits = 32,
  parameter int p_msg_dnbits = 32,
  parameter int p_qdepth     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enq_val,
  input  logic [p_msg_cnbits-1:0] enq_control,
  input  logic [p_msg_dnbits-1:0] enq_data,
  output logic                    full,
  output logic                    deq_val,
  input  logic                    deq_rdy,
  output logic [p_msg_cnbits-1:0] deq_control,
  output logic [p_msg_dnbits-1:0] deq_data
);

  localparam int AW = $clog2(p_qdepth);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [p_msg_cnbits-1:0] control;
    logic [p_msg_dnbits-1:0] data;
  } entry_t;

  entry_t        mem [p_qdepth];
  entry_t        head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  q_state_e      state;
  q_state_e      state_next;
  logic          do_enq;
  logic          do_deq;

  // Next occupancy/state and the zero-on-empty head outputs
  always_comb begin
    do_enq     = enq_val && (state != Q_FULL);
    do_deq     = deq_rdy && (state != Q_EMPTY);
    count_next = count;
    if (do_enq && !do_deq) begin
      count_next = count + CW'(1);
    end else if (!do_enq && do_deq) begin
      count_next = count - CW'(1);
    end
    state_next = Q_PARTIAL;
    if (count_next == '0) begin
      state_next = Q_EMPTY;
    end else if (count_next == CW'(p_qdepth)) begin
      state_next = Q_FULL;
    end
    full        = (state == Q_FULL);
    deq_val     = (state != Q_EMPTY);
    head        = mem[rd_ptr];
    deq_control = deq_val ? head.control : '0;
    deq_data    = deq_val ? head.data    : '0;
  end

  // State, count and pointers; pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= Q_EMPTY;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (do_deq) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage write; contents need no reset because empty heads are masked
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= '{control: enq_control, data: enq_data};
  end

endmodule

// File: rtl/plab4_net_demux_q.sv
// Purpose: steer one val/rdy stream into per-domain FIFOs by domain; drop and count bad domains.
// Latency: 1 cycle from input transfer to the message at its domain's output.
// Backpressure: in_rdy follows only the selected FIFO's full flag (1 for bad domains), never out_rdy.
module plab4_net_demux_q
  import plab4_net_demux_q_pkg::*;
#(
  parameter int p_msg_cnbits  = 32,
  parameter int p_msg_dnbits  = 32,
  parameter int p_num_domains = 2,
  parameter int p_dom_nbits   = 1,
  parameter int p_qdepth      = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [p_dom_nbits-1:0]                domain,
  input  logic                                  in_val,
  output logic                                  in_rdy,
  input  logic [p_msg_cnbits-1:0]               in_msg_control,
  input  logic [p_msg_dnbits-1:0]               in_msg_data,
  output logic [p_num_domains-1:0]              out_val,
  input  logic [p_num_domains-1:0]              out_rdy,
  output logic [p_num_domains*p_msg_cnbits-1:0] out_msg_control,
  output logic [p_num_domains*p_msg_dnbits-1:0] out_msg_data,
  output logic [DROP_CNT_W-1:0]                 drop_count
);

  logic [p_num_domains-1:0] full;
  logic [p_num_domains-1:0] enq_val;
  logic                     dom_hit;
  logic                     drop;

  // Decode domain; an unmatched (out-of-range or unknown) domain is always ready and dropped
  always_comb begin
    in_rdy  = 1'b1;
    enq_val = '0;
    dom_hit = 1'b0;
    for (int d = 0; d < p_num_domains; d++) begin
      if (domain == p_dom_nbits'(d)) begin
        dom_hit    = 1'b1;
        in_rdy     = !full[d];
        enq_val[d] = in_val && !full[d];
      end
    end
    drop = in_val && !dom_hit;
  end

  // Saturating count of discarded messages
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop) begin
      drop_count <= drop_sat_inc(drop_count);
    end
  end

  for (genvar d = 0; d < p_num_domains; d++) begin : g_dom
    plab4_net_demux_q_fifo #(
      .p_msg_cnbits (p_msg_cnbits),
      .p_msg_dnbits (p_msg_dnbits),
      .p_qdepth     (p_qdepth)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .enq_val     (enq_val[d]),
      .enq_control (in_msg_control),
      .enq_data    (in_msg_data),
      .full        (full[d]),
      .deq_val     (out_val[d]),
      .deq_rdy     (out_rdy[d]),
      .deq_control (out_msg_control[d*p_msg_cnbits +: p_msg_cnbits]),
      .deq_data    (out_msg_data[d*p_msg_dnbits +: p_msg_dnbits])
    );
  end

endmodule

// File: tb/tb_plab4_net_demux_q.sv
// Purpose: self-checking bench for plab4_net_demux_q using a queue-level reference model.
// Latency: expects messages one cycle after their transfer edge.
// Backpressure: exercises per-domain stalls, full refusal, bad-domain drops and saturation.
module tb_plab4_net_demux_q;

  localparam int C  = 32;
  localparam int D  = 32;
  localparam int N  = 2;
  localparam int DB = 2;
  localparam int Q  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DB-1:0]   domain = '0;
  logic            in_val = 1'b0;
  logic            in_rdy;
  logic [C-1:0]    in_msg_control = '0;
  logic [D-1:0]    in_msg_data = '0;
  logic [N-1:0]    out_val;
  logic [N-1:0]    out_rdy = '0;
  logic [N*C-1:0]  out_msg_control;
  logic [N*D-1:0]  out_msg_data;
  logic [15:0]     drop_count;

  plab4_net_demux_q #(
    .p_msg_cnbits  (C),
    .p_msg_dnbits  (D),
    .p_num_domains (N),
    .p_dom_nbits   (DB),
    .p_qdepth      (Q)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .domain          (domain),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .in_msg_control  (in_msg_control),
    .in_msg_data     (in_msg_data),
    .out_val         (out_val),
    .out_rdy         (out_rdy),
    .out_msg_control (out_msg_control),
    .out_msg_data    (out_msg_data),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    logic [C-1:0] c;
    logic [D-1:0] d;
  } ent_t;

  ent_t mq [N][$];
  int   m_drop = 0;
  int   pre_sz [N];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: per-domain queues and a saturating drop counter, updated at each edge
  always @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < N; d++) mq[d].delete();
      m_drop = 0;
      cmp_en = 1'b1;
    end else begin
      for (int d = 0; d < N; d++) pre_sz[d] = mq[d].size();
      for (int d = 0; d < N; d++)
        if (pre_sz[d] > 0 && out_rdy[d]) void'(mq[d].pop_front());
      if (in_val) begin
        if (int'(domain) < N) begin
          if (pre_sz[int'(domain)] < Q) mq[int'(domain)].push_back('{c: in_msg_control, d: in_msg_data});
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      logic         exp_rdy;
      logic         ev;
      logic [C-1:0] ec;
      logic [D-1:0] ed;
      exp_rdy = 1'b1;
      if (int'(domain) < N) exp_rdy = (mq[int'(domain)].size() < Q);
      chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      for (int d = 0; d < N; d++) begin
        ev = (mq[d].size() > 0);
        ec = ev ? mq[d][0].c : '0;
        ed = ev ? mq[d][0].d : '0;
        chk("out_val", 64'(out_val[d]), 64'(ev));
        chk("out_msg_control", 64'(out_msg_control[d*C +: C]), 64'(ec));
        chk("out_msg_data", 64'(out_msg_data[d*D +: D]), 64'(ed));
      end
      chk("drop_count", 64'(drop_count), 64'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int dm, input logic [C-1:0] c, input logic [D-1:0] dd);
    domain         = DB'(dm);
    in_val         = 1'b1;
    in_msg_control = c;
    in_msg_data    = dd;
  endtask

  initial begin
    // Reset and first-cycle-after-reset values
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    domain = 2'd0;
    #1 chk("rst_in_rdy_d0", 64'(in_rdy), 64'd1);
    domain = 2'd3;
    #1 chk("rst_in_rdy_d3", 64'(in_rdy), 64'd1);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_out_ctrl", 64'(out_msg_control), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    // Single message to domain 0 visible one cycle later, domain 1 stays zero
    send(0, 32'h11, 32'hAA);
    step();
    in_val = 1'b0;
    #1;
    chk("first_out_val", 64'(out_val), 64'b01);
    chk("first_ctrl0", 64'(out_msg_control[31:0]), 64'h11);
    chk("first_data0", 64'(out_msg_data[31:0]), 64'hAA);
    chk("first_ctrl1", 64'(out_msg_control[63:32]), 64'h0);
    chk("first_data1", 64'(out_msg_data[63:32]), 64'h0);
    out_rdy = 2'b01;
    step();
    out_rdy = 2'b00;

    // Domain 1 stalls full; domain 0 still accepted in the same stall
    send(1, 32'h21, 32'hB1);
    step();
    send(1, 32'h22, 32'hB2);
    step();
    send(1, 32'h23, 32'hB3);
    #1 chk("d1_full_in_rdy", 64'(in_rdy), 64'd0);
    send(0, 32'h31, 32'hC1);
    #1 chk("d0_during_stall_in_rdy", 64'(in_rdy), 64'd1);
    step();
    in_val = 1'b0;
    #1;
    chk("both_out_val", 64'(out_val), 64'b11);
    chk("d0_head_31", 64'(out_msg_control[31:0]), 64'h31);

    // Domain 0 full with simultaneous dequeue: refused now, accepted next cycle
    send(0, 32'h32, 32'hC2);
    step();
    send(0, 32'h33, 32'hC3);
    out_rdy = 2'b01;
    #1 chk("d0_full_in_rdy", 64'(in_rdy), 64'd0);
    step();
    #1;
    chk("d0_after_deq_in_rdy", 64'(in_rdy), 64'd1);
    chk("d0_head_32", 64'(out_msg_control[31:0]), 64'h32);
    step();
    in_val = 1'b0;
    #1 chk("d0_head_33", 64'(out_msg_control[31:0]), 64'h33);

    // Ten messages streamed through domain 0 across many pointer wraps
    for (int i = 0; i < 10; i++) begin
      send(0, 32'h40 + 32'(i), 32'hD0 + 32'(i));
      step();
    end
    in_val = 1'b0;
    #1 chk("wrap_head_49", 64'(out_msg_control[31:0]), 64'h49);
    out_rdy = 2'b11;
    repeat (4) step();
    #1 chk("drained_out_val", 64'(out_val), 64'd0);

    // Out-of-range domain: always ready, dropped and counted
    out_rdy = 2'b00;
    for (int i = 0; i < 5; i++) begin
      send(3, 32'(i), 32'(i));
      #1 chk("drop_in_rdy", 64'(in_rdy), 64'd1);
      step();
    end
    in_val = 1'b0;
    #1;
    chk("drop_count_5", 64'(drop_count), 64'd5);
    chk("drop_no_out_val", 64'(out_val), 64'd0);
    send(3, 32'h0, 32'h0);
    repeat (65534 - 5) step();
    in_val = 1'b0;
    #1 chk("drop_count_fffe", 64'(drop_count), 64'hFFFE);
    in_val = 1'b1;
    repeat (3) step();
    in_val = 1'b0;
    #1 chk("drop_count_sat", 64'(drop_count), 64'hFFFF);

    // Alternate domains with both outputs ready: one-cycle latency, own order
    out_rdy = 2'b11;
    for (int i = 0; i < 8; i++) begin
      send(i % 2, 32'h60 + 32'(i), 32'hE0 + 32'(i));
      step();
      in_val = 1'b0;
      #1;
      chk("alt_out_val", 64'(out_val[i % 2]), 64'd1);
      chk("alt_ctrl", 64'(out_msg_control[(i % 2)*C +: C]), 64'h60 + 64'(i));
    end
    in_val = 1'b0;
    step();

    // Fill both FIFOs then reset for one cycle
    out_rdy = 2'b00;
    send(0, 32'h71, 32'hF1);
    step();
    send(0, 32'h72, 32'hF2);
    step();
    send(1, 32'h81, 32'hA1);
    step();
    send(1, 32'h82, 32'hA2);
    step();
    in_val = 1'b0;
    #1 chk("prefill_out_val", 64'(out_val), 64'b11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_out_val", 64'(out_val), 64'd0);
    chk("mid_rst_ctrl", 64'(out_msg_control), 64'd0);
    chk("mid_rst_data", 64'(out_msg_data), 64'd0);
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
